chip4_valve_sequencer: RTL and testbench

//  Pneumatic controller for the 4-chamber ChIP chip: drives every *_ctrl / pump control line that the

---
 rtl/chip4_valve_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_chip4_valve_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip4_valve_sequencer.sv
// ChIP 4-chamber pneumatic valve sequencer.
// One host command at a time: open route, hold or pump, close, report.
module chip4_valve_sequencer #(
  parameter int PHASE_CYC  = 100,
  parameter int SETTLE_CYC = 50,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_sel,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       inlet_ctrl,
  output logic             prep_inlet_ctrl,
  output logic             prep_outlet_ctrl,
  output logic             stage_inlet_ctrl,
  output logic             stage_outlet_ctrl,
  output logic             bead_ctrl,
  output logic             collect_ctrl,
  output logic             sieve_ctrl,
  output logic [2:0]       pump
);

  localparam int PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYC - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_CYC - 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_PUMP    = 3'd2;
  localparam logic [2:0] OP_BEAD    = 3'd3;
  localparam logic [2:0] OP_COLLECT = 3'd4;
  localparam logic [2:0] OP_FLUSH   = 3'd5;

  localparam logic [11:0] ALL_CLOSED = 12'hfff;
  localparam logic [2:0]  PUMP_IDLE  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_RUN,
    S_CLOSE
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] unit_cnt;
  logic [PW-1:0]    ph_cnt;
  logic [2:0]       phase;
  logic [SW-1:0]    st_cnt;
  logic             aborted;
  logic [11:0]      ctrl_q;
  logic [2:0]       pump_q;

  // Packed route: {inlet[4:0], prep_in, prep_out,
  // stage_in, stage_out, bead, collect, sieve}; 0 = open.
  function automatic logic [11:0] route_of(
    input logic [2:0] op,
    input logic [2:0] sel
  );
    logic [11:0] r;
    r = ALL_CLOSED;
    unique case (1'b1)
      (op == OP_LOAD): begin
        r[11:7] = ~(5'b00001 << sel);
        r[6]    = 1'b0;
      end
      (op == OP_PUMP): begin
        r[4] = 1'b0;
        r[3] = 1'b0;
      end
      (op == OP_BEAD): begin
        r[2] = 1'b0;
        r[4] = 1'b0;
      end
      (op == OP_COLLECT): begin
        r[3] = 1'b0;
        r[1] = 1'b0;
        r[0] = 1'b0;
      end
      (op == OP_FLUSH): r[5] = 1'b0;
      default: r = ALL_CLOSED;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] pat(input logic [2:0] ph);
    logic [2:0] p;
    unique case (ph)
      3'd0:    p = 3'b110;
      3'd1:    p = 3'b100;
      3'd2:    p = 3'b101;
      3'd3:    p = 3'b001;
      3'd4:    p = 3'b011;
      3'd5:    p = 3'b010;
      default: p = PUMP_IDLE;
    endcase
    return p;
  endfunction

  logic pump_op;
  logic illegal;

  assign pump_op = (op_q == OP_PUMP) || (op_q == OP_BEAD) ||
                   (op_q == OP_COLLECT);

  assign illegal = (cmd_op > OP_FLUSH) ||
                   ((cmd_op == OP_LOAD) && (cmd_sel > 3'd4));

  assign cmd_ready = (state == S_IDLE);

  assign inlet_ctrl        = ctrl_q[11:7];
  assign prep_inlet_ctrl   = ctrl_q[6];
  assign prep_outlet_ctrl  = ctrl_q[5];
  assign stage_inlet_ctrl  = ctrl_q[4];
  assign stage_outlet_ctrl = ctrl_q[3];
  assign bead_ctrl         = ctrl_q[2];
  assign collect_ctrl      = ctrl_q[1];
  assign sieve_ctrl        = ctrl_q[0];
  assign pump              = pump_q;

  // Sequencer FSM with registered valve, pump and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      unit_cnt <= '0;
      ph_cnt   <= '0;
      phase    <= '0;
      st_cnt   <= '0;
      aborted  <= 1'b0;
      ctrl_q   <= ALL_CLOSED;
      pump_q   <= PUMP_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            unit_cnt <= cmd_count;
            st_cnt   <= ST_LAST;
            aborted  <= 1'b0;
            if (illegal) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if ((cmd_op == OP_NOP) ||
                         (cmd_count == '0)) begin
              done <= 1'b1;
            end else begin
              state  <= S_OPEN;
              busy   <= 1'b1;
              ctrl_q <= route_of(cmd_op, cmd_sel);
            end
          end
        end
        S_OPEN: begin
          if (abort) begin
            state   <= S_CLOSE;
            aborted <= 1'b1;
            ctrl_q  <= ALL_CLOSED;
            pump_q  <= PUMP_IDLE;
            st_cnt  <= ST_LAST;
          end else if (st_cnt == '0) begin
            state  <= S_RUN;
            ph_cnt <= PH_LAST;
            phase  <= 3'd0;
            pump_q <= pump_op ? pat(3'd0) : PUMP_IDLE;
          end else begin
            st_cnt <= st_cnt - SW'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_CLOSE;
            aborted <= 1'b1;
            ctrl_q  <= ALL_CLOSED;
            pump_q  <= PUMP_IDLE;
            st_cnt  <= ST_LAST;
          end else if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - PW'(1);
          end else begin
            ph_cnt <= PH_LAST;
            if (pump_op && (phase != 3'd5)) begin
              phase  <= phase + 3'd1;
              pump_q <= pat(phase + 3'd1);
            end else if (unit_cnt == CNT_W'(1)) begin
              state  <= S_CLOSE;
              ctrl_q <= ALL_CLOSED;
              pump_q <= PUMP_IDLE;
              st_cnt <= ST_LAST;
            end else begin
              unit_cnt <= unit_cnt - CNT_W'(1);
              phase    <= 3'd0;
              if (pump_op) begin
                pump_q <= pat(3'd0);
              end
            end
          end
        end
        S_CLOSE: begin
          if (st_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= aborted;
          end else begin
            st_cnt <= st_cnt - SW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip4_valve_sequencer.sv
// Self-checking bench for chip4_valve_sequencer.
// Per-cycle expected output timelines queued per command.
module tb_chip4_valve_sequencer;

  localparam int PH = 4;
  localparam int ST = 2;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [2:0]    cmd_sel;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic [4:0]    inlet_ctrl;
  logic          prep_inlet_ctrl;
  logic          prep_outlet_ctrl;
  logic          stage_inlet_ctrl;
  logic          stage_outlet_ctrl;
  logic          bead_ctrl;
  logic          collect_ctrl;
  logic          sieve_ctrl;
  logic [2:0]    pump;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [2:0]  pmp;
    logic        bsy;
    logic        dn;
    logic        er;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_assert;
  int   n_fail;

  logic [2:0] pat [6] = '{3'b110, 3'b100, 3'b101,
                          3'b001, 3'b011, 3'b010};

  chip4_valve_sequencer #(
    .PHASE_CYC (PH),
    .SETTLE_CYC(ST),
    .CNT_W     (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_sel          (cmd_sel),
    .cmd_count        (cmd_count),
    .abort            (abort),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .inlet_ctrl       (inlet_ctrl),
    .prep_inlet_ctrl  (prep_inlet_ctrl),
    .prep_outlet_ctrl (prep_outlet_ctrl),
    .stage_inlet_ctrl (stage_inlet_ctrl),
    .stage_outlet_ctrl(stage_outlet_ctrl),
    .bead_ctrl        (bead_ctrl),
    .collect_ctrl     (collect_ctrl),
    .sieve_ctrl       (sieve_ctrl),
    .pump             (pump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t idle_rec();
    exp_t e;
    e.ctrl = 12'hfff;
    e.pmp  = 3'b111;
    e.bsy  = 1'b0;
    e.dn   = 1'b0;
    e.er   = 1'b0;
    e.rdy  = 1'b1;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t e;
    e = {inlet_ctrl, prep_inlet_ctrl, prep_outlet_ctrl,
         stage_inlet_ctrl, stage_outlet_ctrl, bead_ctrl,
         collect_ctrl, sieve_ctrl, pump, busy, done, err,
         cmd_ready};
    return e;
  endfunction

  function automatic logic [11:0] exp_route(int op, int sel);
    logic [4:0] in;
    in = 5'b11111;
    if (sel >= 0 && sel < 5) in[sel] = 1'b0;
    case (op)
      1: return {in, 1'b0, 6'b111111};
      2: return {5'h1f, 2'b11, 2'b00, 3'b111};
      3: return {5'h1f, 2'b11, 2'b01, 3'b011};
      4: return {5'h1f, 2'b11, 2'b10, 3'b100};
      5: return {5'h1f, 2'b10, 2'b11, 3'b111};
      default: return 12'hfff;
    endcase
  endfunction

  task automatic push_expect(int op, int sel, int count,
                             int abort_at);
    exp_t e;
    int   run;
    int   last;
    bit   pop_;
    bit   ab;
    if (op > 5 || (op == 1 && sel > 4)) begin
      e = idle_rec();
      e.dn = 1'b1;
      e.er = 1'b1;
      q.push_back(e);
      q.push_back(idle_rec());
      return;
    end
    if (op == 0 || count == 0) begin
      e = idle_rec();
      e.dn = 1'b1;
      q.push_back(e);
      q.push_back(idle_rec());
      return;
    end
    pop_ = (op == 2 || op == 3 || op == 4);
    run  = pop_ ? count * 6 * PH : count * PH;
    last = ST + run;
    ab   = 1'b0;
    if (abort_at > 0 && abort_at <= last) begin
      last = abort_at;
      ab   = 1'b1;
    end
    for (int k = 1; k <= last; k++) begin
      e = idle_rec();
      e.ctrl = exp_route(op, sel);
      e.bsy  = 1'b1;
      e.rdy  = 1'b0;
      if (pop_ && k > ST) e.pmp = pat[((k - ST - 1) / PH) % 6];
      q.push_back(e);
    end
    for (int k = 0; k < ST; k++) begin
      e = idle_rec();
      e.bsy = 1'b1;
      e.rdy = 1'b0;
      q.push_back(e);
    end
    e = idle_rec();
    e.dn = 1'b1;
    e.er = ab;
    q.push_back(e);
    q.push_back(idle_rec());
  endtask

  task automatic run_cmd(int op, int sel, int count,
                         int abort_at, string name);
    exp_t e;
    exp_t got;
    int   k;
    @(negedge clk);
    rst = 1'b0;
    n_assert++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_sel   = sel[2:0];
    cmd_count = count[CW-1:0];
    push_expect(op, sel, count, abort_at);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      abort = (k == abort_at);
      e = q.pop_front();
      got = observe();
      n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s T+%0d: got ctrl=%b pump=%b bdeR=%b%b%b%b want ctrl=%b pump=%b bdeR=%b%b%b%b",
                 name, k, got.ctrl, got.pmp, got.bsy, got.dn,
                 got.er, got.rdy, e.ctrl, e.pmp, e.bsy, e.dn,
                 e.er, e.rdy);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    cmd_op = '0;
    cmd_sel = '0;
    cmd_count = '0;
    @(posedge clk);
    @(negedge clk);
    got = observe();
    n_assert++;
    if (got !== idle_rec()) begin
      n_fail++;
      $display("FAIL reset: got %b want %b", got, idle_rec());
    end
  endtask

  task automatic test_load();
    run_cmd(1, 2, 3, -1, "load_sel2_c3");
  endtask

  task automatic test_pump();
    run_cmd(2, 0, 2, -1, "pump_c2");
  endtask

  task automatic test_immediate();
    run_cmd(6, 0, 3, -1, "illegal_op6");
    run_cmd(7, 0, 1, -1, "illegal_op7");
    run_cmd(1, 5, 2, -1, "load_sel5");
    run_cmd(0, 0, 4, -1, "nop");
    run_cmd(2, 0, 0, -1, "pump_c0");
  endtask

  task automatic test_other_ops();
    run_cmd(5, 0, 1, -1, "flush_c1");
    run_cmd(3, 0, 1, -1, "bead_c1");
    run_cmd(1, 4, 1, -1, "load_sel4_c1");
  endtask

  task automatic test_abort();
    run_cmd(4, 0, 5, 12, "collect_abort_run");
    run_cmd(2, 0, 1, 1, "pump_abort_open");
    run_cmd(1, 0, 1, 7, "load_abort_close_ignored");
  endtask

  task automatic test_back_to_back();
    run_cmd(3, 0, 1, -1, "b2b_bead");
    run_cmd(1, 1, 2, -1, "b2b_load");
  endtask

  task automatic test_rst_mid_pump();
    exp_t got;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_sel   = 3'd0;
    cmd_count = 16'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst       = 1'b1;
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_sel   = 3'd0;
    cmd_count = 16'd1;
    @(negedge clk);
    abort = 1'b0;
    got = observe();
    n_assert++;
    if (got !== idle_rec()) begin
      n_fail++;
      $display("FAIL rst_mid_pump: got %b want %b", got, idle_rec());
    end
    @(negedge clk);
    got = observe();
    n_assert++;
    if (got !== idle_rec()) begin
      n_fail++;
      $display("FAIL rst_hold_valid: got %b want %b", got, idle_rec());
    end
    run_cmd(1, 0, 1, -1, "load_after_rst");
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_load();
    test_pump();
    test_immediate();
    test_other_ops();
    test_abort();
    test_back_to_back();
    test_rst_mid_pump();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
